// File: rtl/au_pkg.sv
// Shared arithmetic-unit package: prefix-architecture codes, parameter
// range check and binary-to-Gray constant conversion.
package au_pkg;

  localparam int ARCH_RIPPLE   = 0;
  localparam int ARCH_SKLANSKY = 1;
  localparam int ARCH_KOGGE    = 2;

  // Binary to Gray code; used for constants derived from parameters.
  function automatic longint unsigned bin2gray(input longint unsigned b);
    return b ^ (b >> 1);
  endfunction

  // Legal parameter set: WIDTH 1..63, ARCH 0..2, INIT representable in WIDTH bits.
  function automatic bit params_ok(input int width, input int arch,
                                   input longint unsigned init);
    if (width < 1 || width > 63) return 1'b0;
    if (arch < ARCH_RIPPLE || arch > ARCH_KOGGE) return 1'b0;
    if (init >= (64'd1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/au_incdec_gray.sv
// Combinational Gray-code +/-1 step. Exactly one bit of a flips; end_flag
// marks that a is at the range end in the requested direction.
module au_incdec_gray
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic             up,
  output logic [WIDTH-1:0] z,
  output logic             end_flag
);

  localparam logic [WIDTH-1:0] GMAX = WIDTH'(bin2gray((64'd1 << WIDTH) - 64'd1));

  logic [WIDTH-1:0] zero_run;   // zero_run[i]: a[i:0] is all zero
  logic [WIDTH-1:0] lsb;        // one-hot lowest set bit of a
  logic [WIDTH-1:0] flip;
  logic             use_bit0;

  au_prefix_and #(.WIDTH(WIDTH), .ARCH(ARCH)) u_pfx (
    .x (~a),
    .y (zero_run)
  );

  // Choose the single bit to flip from parity and the lowest set bit.
  always_comb begin
    lsb    = '0;
    lsb[0] = a[0];
    for (int i = 1; i < WIDTH; i++) begin
      lsb[i] = a[i] & zero_run[i-1];
    end
    use_bit0 = up ? ~(^a) : (^a);
    flip     = '0;
    if (use_bit0) begin
      flip[0] = 1'b1;
    end else begin
      flip = lsb << 1;
      // Lowest set bit at the MSB, or no bit set at all: flip the MSB (wrap).
      if (lsb[WIDTH-1] || zero_run[WIDTH-1]) flip[WIDTH-1] = 1'b1;
    end
  end

  assign z        = a ^ flip;
  assign end_flag = up ? (a == GMAX) : (a == '0);

endmodule

// File: rtl/au_prefix_and.sv
// Parallel-prefix AND: y[i] = &x[i:0]. ARCH picks ripple, Sklansky or
// Kogge-Stone; all three produce identical results.
module au_prefix_and
  import au_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] tmp;

  // Prefix network selected at elaboration time by ARCH.
  always_comb begin
    acc = x;
    tmp = x;
    if (ARCH == ARCH_RIPPLE) begin
      for (int i = 1; i < WIDTH; i++) begin
        acc[i] = acc[i-1] & x[i];
      end
    end else if (ARCH == ARCH_SKLANSKY) begin
      // At level k only nodes with bit k set update, and their source has
      // bit k clear, so in-place update is safe.
      for (int k = 0; (1 << k) < WIDTH; k++) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (((i >> k) & 1) == 1) begin
            acc[i] = acc[i] & acc[((i >> k) << k) - 1];
          end
        end
      end
    end else begin
      for (int d = 1; d < WIDTH; d = d << 1) begin
        tmp = acc;
        for (int i = d; i < WIDTH; i++) begin
          acc[i] = tmp[i] & tmp[i-d];
        end
      end
    end
  end

  assign y = acc;

endmodule

// File: rtl/au_cnt_gray.sv
// Registered Gray-code up/down counter with load, wrap/saturate,
// terminal-count flag and one-cycle overflow pulse.
module au_cnt_gray
  import au_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter int          ARCH  = 0,
  parameter int          WRAP  = 1,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] z,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] GMAX  = WIDTH'(bin2gray((64'd1 << WIDTH) - 64'd1));
  localparam logic [WIDTH-1:0] GINIT = WIDTH'(bin2gray(64'(INIT)));

  if (!params_ok(WIDTH, ARCH, 64'(INIT))) begin : g_bad_param
    $error("au_cnt_gray: illegal WIDTH/ARCH/INIT");
  end

  logic [WIDTH-1:0] z_q, z_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step;
  logic             end_flag;

  au_incdec_gray #(.WIDTH(WIDTH), .ARCH(ARCH)) u_step (
    .a        (z_q),
    .up       (up),
    .z        (step),
    .end_flag (end_flag)
  );

  // Load/count priority and wrap-or-saturate at the range ends.
  always_comb begin
    z_d   = z_q;
    ovf_d = 1'b0;
    if (load) begin
      z_d = d;
    end else if (en) begin
      if (end_flag) begin
        ovf_d = 1'b1;
        if (WRAP != 0) z_d = up ? '0 : GMAX;
      end else begin
        z_d = step;
      end
    end
  end

  // State and overflow registers; reset overrides load and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q   <= GINIT;
      ovf_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      ovf_q <= ovf_d;
    end
  end

  assign z   = z_q;
  assign ovf = ovf_q;
  assign tc  = en & end_flag;

endmodule
